// File: rtl/uart_tx.sv
// uart_tx -- serial transmitter with a THR/TSR double buffer.
//
// A byte is written into the Transmit Holding Register (THR). When the line
// is free, the THR is copied into the Transmit Shift Register (TSR). The TSR
// is then sent as a frame on tx_pin:
//   start (0), data[0..7] LSB first, optional even parity, stop (1).
// Bit timing comes from a 16x tick divider, so one bit period is
// 16*CLKS_PER_TICK clk cycles. This matches the 16x sampling in uart_rx.
//
// Parameters
//   CLKS_PER_TICK : clk cycles per 16x tick (>= 1)
//   PARITY_EN     : 1 inserts an even parity bit (^data) after data bit 7
//
// Ports
//   clk       : single clock
//   rst       : synchronous, active-high reset
//   thr_wr    : THR write strobe; accepted only when thr_empty is 1
//   THR       : byte captured on an accepted write
//   tx_pin    : serial output, idles high
//   thr_empty : 1 when the THR can take a write
//   tx_busy   : 1 while any frame bit (start..stop) is on the line
//   tx_done   : one-cycle pulse during the last cycle of each stop bit
//   state_dbg : current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: THR accepts on a rising clk edge where thr_wr=1 and
// thr_empty=1. There is no ready/valid back-pressure beyond thr_empty. A
// write while thr_empty=0 is silently ignored and leaves the THR unchanged.
//
// All outputs are registered.

module uart_tx #(
  parameter int CLKS_PER_TICK = 16,
  parameter bit PARITY_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       thr_wr,
  input  logic [7:0] THR,
  output logic       tx_pin,
  output logic       thr_empty,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Divider width. A single bit is kept even when CLKS_PER_TICK is 1, so
  // that the counter declaration stays legal.
  localparam int DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  // Last divider value of a tick.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_TICK - 1);

  // Counter position one clk before the end of a bit. tx_done is registered,
  // so it is raised from here and is then high during the final cycle of the
  // stop bit. With one clk per tick, that position is tick 14.
  // Otherwise it is tick 15 at divider value CLKS_PER_TICK-2.
  localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'((CLKS_PER_TICK > 1) ? CLKS_PER_TICK - 2 : 0);
  localparam logic [3:0]       SUB_PRE = (CLKS_PER_TICK > 1) ? 4'd15 : 4'd14;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       sub_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       thr_reg;
  logic [7:0]       tsr;

  logic tick;
  logic bit_end;
  logic pre_end;

  assign tick    = (div_cnt == DIV_LAST);
  assign bit_end = tick && (sub_cnt == 4'd15);
  assign pre_end = (div_cnt == DIV_PRE) && (sub_cnt == SUB_PRE);

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      sub_cnt   <= '0;
      bit_idx   <= '0;
      thr_reg   <= '0;
      tsr       <= '0;
      tx_pin    <= 1'b1;
      thr_empty <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // THR write. This branch needs thr_empty=1, while a THR->TSR transfer
      // below needs thr_empty=0. The two never update thr_empty in the
      // same cycle. A write on the transfer edge is therefore dropped.
      if (thr_wr && thr_empty) begin
        thr_reg   <= THR;
        thr_empty <= 1'b0;
      end

      // Bit timing runs only while a frame is on the line. Both counters
      // wrap to 0 at every bit end. A frame load clears them again below.
      if (state != S_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          sub_cnt <= sub_cnt + 4'd1;
        end
      end

      case (state)
        S_IDLE: begin
          tx_pin <= 1'b1;
          if (!thr_empty) begin
            tsr       <= thr_reg;
            thr_empty <= 1'b1;
            tx_pin    <= 1'b0;
            tx_busy   <= 1'b1;
            div_cnt   <= '0;
            sub_cnt   <= '0;
            bit_idx   <= '0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_pin  <= tsr[0];
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY_EN) begin
                tx_pin <= ^tsr;
                state  <= S_PARITY;
              end else begin
                tx_pin <= 1'b1;
                state  <= S_STOP;
              end
            end else begin
              tx_pin  <= tsr[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx_pin <= 1'b1;
            state  <= S_STOP;
          end
        end

        S_STOP: begin
          if (pre_end) begin
            tx_done <= 1'b1;
          end
          if (bit_end) begin
            if (!thr_empty) begin
              // Back-to-back: the next start bit follows the stop bit
              // directly. tx_busy stays high across the boundary.
              tsr       <= thr_reg;
              thr_empty <= 1'b1;
              tx_pin    <= 1'b0;
              div_cnt   <= '0;
              sub_cnt   <= '0;
              bit_idx   <= '0;
              state     <= S_START;
            end else begin
              tx_pin  <= 1'b1;
              tx_busy <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end

        default: begin
          tx_pin  <= 1'b1;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Instance A uses CLKS_PER_TICK=1 and PARITY_EN=1.
// Instance B uses CLKS_PER_TICK=2 and PARITY_EN=0.
// Expected frames are hand-computed bit patterns.
// Frame bit k is the k-th bit on the line, so bit 0 is the start bit.

module tb_uart_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       thr_wr_a, thr_wr_b;
  logic [7:0] thr_a, thr_b;

  logic       tx_pin_a, thr_empty_a, tx_busy_a, tx_done_a;
  logic [2:0] state_a;
  logic       tx_pin_b, thr_empty_b, tx_busy_b, tx_done_b;
  logic [2:0] state_b;

  uart_tx #(.CLKS_PER_TICK(1), .PARITY_EN(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .thr_wr    (thr_wr_a),
    .THR       (thr_a),
    .tx_pin    (tx_pin_a),
    .thr_empty (thr_empty_a),
    .tx_busy   (tx_busy_a),
    .tx_done   (tx_done_a),
    .state_dbg (state_a)
  );

  uart_tx #(.CLKS_PER_TICK(2), .PARITY_EN(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .thr_wr    (thr_wr_b),
    .THR       (thr_b),
    .tx_pin    (tx_pin_b),
    .thr_empty (thr_empty_b),
    .tx_busy   (tx_busy_b),
    .tx_done   (tx_done_b),
    .state_dbg (state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens at the falling edge.

  task automatic write_a(input logic [7:0] d);
    thr_a    = d;
    thr_wr_a = 1'b1;
    @(negedge clk);
    thr_wr_a = 1'b0;
  endtask

  // This task is entered on the falling edge right after the THR write was
  // accepted, or on the last stop-bit cycle of the previous frame in the
  // back-to-back case. It checks one 176-cycle frame.
  // wr_mode 1 writes wr_d on the THR->TSR transfer edge; that write must be
  // dropped. wr_mode 2 writes wr_d on the following edge; that write must
  // be accepted.
  task automatic frame_a(input logic [10:0] frame, input int wr_mode,
                         input logic [7:0] wr_d, input bit idle_after);
    chk("pre_empty", thr_empty_a, 0);
    chk("pre_pin", tx_pin_a, 1);
    if (wr_mode == 1) begin
      thr_a    = wr_d;
      thr_wr_a = 1'b1;
    end
    for (int c = 0; c < 176; c++) begin
      @(negedge clk);
      chk("frame_pin", tx_pin_a, frame[c/16]);
      chk("frame_busy", tx_busy_a, 1);
      chk("frame_done", tx_done_a, (c == 175) ? 1 : 0);
      if (c == 0) begin
        chk("xfer_empty", thr_empty_a, 1);
        if (wr_mode == 1) thr_wr_a = 1'b0;
        if (wr_mode == 2) begin
          thr_a    = wr_d;
          thr_wr_a = 1'b1;
        end
      end
      if (c == 1 && wr_mode == 2) begin
        thr_wr_a = 1'b0;
        chk("next_accept", thr_empty_a, 0);
      end
    end
    if (idle_after) begin
      @(negedge clk);
      chk("end_busy", tx_busy_a, 0);
      chk("end_pin", tx_pin_a, 1);
      chk("end_done", tx_done_a, 0);
      chk("end_empty", thr_empty_a, 1);
      chk("end_state", state_a, 0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("gap_pin", tx_pin_a, 1);
        chk("gap_busy", tx_busy_a, 0);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // {stop, parity, d7..d0, start}
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] f0f;
    logic [9:0]  fb;

    vecs[0] = '{data: 8'hA5, frame: 11'b10101001010};
    vecs[1] = '{data: 8'h00, frame: 11'b10000000000};
    vecs[2] = '{data: 8'h80, frame: 11'b11100000000};
    vecs[3] = '{data: 8'h7E, frame: 11'b10011111100};
    vecs[4] = '{data: 8'hFF, frame: 11'b10111111110};

    rst      = 1'b1;
    thr_wr_a = 1'b0;
    thr_wr_b = 1'b0;
    thr_a    = 8'h00;
    thr_b    = 8'h00;

    // Reset values after the first edge with rst=1.
    @(negedge clk);
    chk("rst_pin", tx_pin_a, 1);
    chk("rst_empty", thr_empty_a, 1);
    chk("rst_busy", tx_busy_a, 0);
    chk("rst_done", tx_done_a, 0);
    chk("rst_state", state_a, 0);
    chk("rst_pin_b", tx_pin_b, 1);
    @(negedge clk);
    rst = 1'b0;

    // The line stays idle for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_pin", tx_pin_a, 1);
      chk("idle_empty", thr_empty_a, 1);
      chk("idle_busy", tx_busy_a, 0);
      chk("idle_done", tx_done_a, 0);
    end

    // Table-driven single frames.
    foreach (vecs[i]) begin
      write_a(vecs[i].data);
      frame_a(vecs[i].frame, 0, 8'h00, 1'b1);
    end

    // Back-to-back: 0x01 (parity 1), then 0xFF (parity 0). The second write
    // is issued as soon as thr_empty rises. The frames must be contiguous.
    write_a(8'h01);
    frame_a(11'b11000000010, 2, 8'hFF, 1'b0);
    frame_a(11'b10111111110, 0, 8'h00, 1'b1);

    // A write of 0x55 on the transfer edge, while thr_empty=0, is dropped.
    write_a(8'h3C);
    frame_a(11'b10001111000, 1, 8'h55, 1'b1);

    // Reset during data bit 4 of frame 0x0F. A second byte is already
    // waiting in the THR and must be discarded.
    f0f = 11'b10000011110;
    write_a(8'h0F);
    for (int c = 0; c <= 88; c++) begin
      @(negedge clk);
      chk("abort_pin", tx_pin_a, f0f[c/16]);
      if (c == 0) begin
        thr_a    = 8'hAA;
        thr_wr_a = 1'b1;
      end
      if (c == 1) thr_wr_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rst_pin", tx_pin_a, 1);
    chk("abort_rst_busy", tx_busy_a, 0);
    chk("abort_rst_empty", thr_empty_a, 1);
    chk("abort_rst_done", tx_done_a, 0);
    chk("abort_rst_state", state_a, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("abort_idle_pin", tx_pin_a, 1);
      chk("abort_idle_busy", tx_busy_a, 0);
      chk("abort_idle_done", tx_done_a, 0);
    end

    // Instance B sends 0x80 with no parity: 10 bits of 32 cycles each.
    fb = 10'b1100000000;
    thr_b    = 8'h80;
    thr_wr_b = 1'b1;
    @(negedge clk);
    thr_wr_b = 1'b0;
    chk("b_accept_empty", thr_empty_b, 0);
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      chk("b_pin", tx_pin_b, fb[c/32]);
      chk("b_busy", tx_busy_b, 1);
      chk("b_done", tx_done_b, (c == 319) ? 1 : 0);
    end
    @(negedge clk);
    chk("b_end_busy", tx_busy_b, 0);
    chk("b_end_pin", tx_pin_b, 1);
    chk("b_end_done", tx_done_b, 0);
    chk("b_end_state", state_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
